drag_race_timer: RTL and testbench

//  Racer-side end of the drag-race christmas tree. Consumes the tree's GRN/RED lights plus
//  the stage beam (SB) and finish beam (FB) switches. Measures reaction time (green -> car

---
 rtl/drag_pkg.sv | 24 ++
 rtl/drag_race_timer_if.sv | 30 +++
 rtl/ms_tick_gen.sv | 34 +++
 rtl/drag_race_timer.sv | 136 +++++++++++++
 tb/tb_drag_race_timer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/drag_pkg.sv
// Shared definitions for the drag-race tree and the racer-side timer.
// The state encoding matches the tree's encoding.
package drag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_REACT = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_FOUL  = 3'd5,
    ST_TOUT  = 3'd6
  } state_t;

  localparam int TICK_DIV_DEF  = 50_000;
  localparam int RT_W_DEF      = 12;
  localparam int ET_W_DEF      = 16;
  localparam int MAX_ET_MS_DEF = 20_000;

  function automatic logic is_timing(input state_t st);
    return (st == ST_REACT) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/drag_race_timer_if.sv
// Tree/racer signal bundle: lights and beams in, timing results and status out.
interface drag_race_timer_if
  import drag_pkg::*;
#(
  parameter int RT_W = RT_W_DEF,
  parameter int ET_W = ET_W_DEF
) ();

  logic            GRN;
  logic            RED;
  logic            SB;
  logic            FB;
  logic [RT_W-1:0] RT_MS;
  logic [ET_W-1:0] ET_MS;
  logic            Busy;
  logic            Done;
  logic            Foul;
  logic            Timeout;

  modport master (
    output GRN, RED, SB, FB,
    input  RT_MS, ET_MS, Busy, Done, Foul, Timeout
  );

  modport slave (
    input  GRN, RED, SB, FB,
    output RT_MS, ET_MS, Busy, Done, Foul, Timeout
  );

endinterface

// File: rtl/ms_tick_gen.sv
// Free-running prescaler that raises Tick for one cycle every TICK_DIV clocks.
// Clr restarts the period so the first tick comes a full period after it.
module ms_tick_gen
  import drag_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clr,
  output logic Tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Period counter, wraps on the tick cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_r <= '0;
    end else if (Clr) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign Tick = (cnt_r == LAST);

endmodule

// File: rtl/drag_race_timer.sv
// Racer-side timer: reaction time (green -> stage-beam exit) and elapsed time
// (stage-beam exit -> finish-beam break) in ms, plus foul and timeout status.
module drag_race_timer
  import drag_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int RT_W      = RT_W_DEF,
  parameter int ET_W      = ET_W_DEF,
  parameter int MAX_ET_MS = MAX_ET_MS_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  drag_race_timer_if.slave  bus
);

  localparam logic [RT_W-1:0] RT_MAX   = '1;
  localparam logic [ET_W-1:0] ET_LIMIT = ET_W'(MAX_ET_MS);

  logic            sb_meta_r, sb_sync_r;
  logic            fb_meta_r, fb_sync_r, fb_prev_r;
  logic            finish_s;
  logic            tick_s;
  logic            clr_s;
  state_t          state_r, state_nx;
  logic [RT_W-1:0] rt_r, rt_nx;
  logic [ET_W-1:0] et_r, et_nx;
  logic            busy_r, done_r, foul_r, tout_r;

  // Beam synchronisers and finish-beam edge history.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sb_meta_r <= 1'b0;
      sb_sync_r <= 1'b0;
      fb_meta_r <= 1'b0;
      fb_sync_r <= 1'b0;
      fb_prev_r <= 1'b0;
    end else begin
      sb_meta_r <= bus.SB;
      sb_sync_r <= sb_meta_r;
      fb_meta_r <= bus.FB;
      fb_sync_r <= fb_meta_r;
      fb_prev_r <= fb_sync_r;
    end
  end

  // A beam already broken when RUN starts is not a finish; only a rising edge is.
  assign finish_s = fb_sync_r & ~fb_prev_r;
  assign clr_s    = (state_nx != state_r) && is_timing(state_nx);

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .Clr   (clr_s),
    .Tick  (tick_s)
  );

  // Next-state logic; RED outranks every other input while staged or reacting.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sb_sync_r) state_nx = ST_ARMED;
        else           state_nx = ST_IDLE;
      end
      ST_ARMED: begin
        if (bus.RED)        state_nx = ST_FOUL;
        else if (bus.GRN)   state_nx = ST_REACT;
        else if (!sb_sync_r) state_nx = ST_IDLE;
        else                state_nx = ST_ARMED;
      end
      ST_REACT: begin
        if (bus.RED)         state_nx = ST_FOUL;
        else if (!sb_sync_r) state_nx = ST_RUN;
        else                 state_nx = ST_REACT;
      end
      ST_RUN: begin
        if (finish_s)              state_nx = ST_DONE;
        else if (et_r == ET_LIMIT) state_nx = ST_TOUT;
        else                       state_nx = ST_RUN;
      end
      ST_DONE: state_nx = ST_DONE;
      ST_FOUL: state_nx = ST_FOUL;
      ST_TOUT: state_nx = ST_TOUT;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counter updates; a tick on the exit cycle is still counted.
  always_comb begin
    rt_nx = rt_r;
    et_nx = et_r;
    if ((state_r == ST_ARMED) && (state_nx == ST_REACT)) begin
      rt_nx = '0;
    end else if ((state_r == ST_REACT) && tick_s && (rt_r != RT_MAX)) begin
      rt_nx = rt_r + RT_W'(1);
    end else begin
      rt_nx = rt_r;
    end
    if ((state_r == ST_REACT) && (state_nx == ST_RUN)) begin
      et_nx = '0;
    end else if ((state_r == ST_RUN) && tick_s && (et_r != ET_LIMIT)) begin
      et_nx = et_r + ET_W'(1);
    end else begin
      et_nx = et_r;
    end
  end

  // State, results and status flags, all decoded from the next state so they align with it.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
      rt_r    <= '0;
      et_r    <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      foul_r  <= 1'b0;
      tout_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      rt_r    <= rt_nx;
      et_r    <= et_nx;
      busy_r  <= is_timing(state_nx);
      done_r  <= (state_nx == ST_DONE);
      foul_r  <= (state_nx == ST_FOUL);
      tout_r  <= (state_nx == ST_TOUT);
    end
  end

  assign bus.RT_MS   = rt_r;
  assign bus.ET_MS   = et_r;
  assign bus.Busy    = busy_r;
  assign bus.Done    = done_r;
  assign bus.Foul    = foul_r;
  assign bus.Timeout = tout_r;

endmodule

// File: tb/tb_drag_race_timer.sv
// Bench for drag_race_timer at TICK_DIV=4, MAX_ET_MS=50: directed races, results
// scored by a monitor whenever a terminal flag rises.
module tb_drag_race_timer;
  import drag_pkg::*;

  localparam int TD    = 4;
  localparam int RW    = 12;
  localparam int EW    = 16;
  localparam int MAXET = 50;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  drag_race_timer_if #(.RT_W(RW), .ET_W(EW)) bus ();

  drag_race_timer #(
    .TICK_DIV(TD), .RT_W(RW), .ET_W(EW), .MAX_ET_MS(MAXET)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [RW-1:0] rt;
    logic [EW-1:0] et;
    logic          done;
    logic          foul;
    logic          tout;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic push_exp(input int rt, input int et, input bit d, input bit f, input bit t);
    exp_t e;
    e.rt   = RW'(rt);
    e.et   = EW'(et);
    e.done = d;
    e.foul = f;
    e.tout = t;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: a rising terminal flag is one presented result.
  logic mon_term;
  logic mon_prev = 1'b0;
  exp_t mon_e;
  always @(negedge Clock) begin
    mon_term = bus.Done | bus.Foul | bus.Timeout;
    if (mon_term === 1'b1 && mon_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: rt=%0d et=%0d with no race pending", bus.RT_MS, bus.ET_MS);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_rt",      32'(bus.RT_MS),   32'(mon_e.rt));
        check("result_et",      32'(bus.ET_MS),   32'(mon_e.et));
        check("result_done",    32'(bus.Done),    32'(mon_e.done));
        check("result_foul",    32'(bus.Foul),    32'(mon_e.foul));
        check("result_timeout", 32'(bus.Timeout), 32'(mon_e.tout));
      end
    end
    mon_prev = mon_term;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset   = 1'b0;
    bus.SB  = 1'b0;
    bus.FB  = 1'b0;
    bus.GRN = 1'b0;
    bus.RED = 1'b0;
    cycles(3);
    Reset = 1'b1;
  endtask

  // Car into the stage beam; after 4 clocks the timer is ARMED.
  task automatic stage();
    bus.SB = 1'b1;
    cycles(4);
  endtask

  task automatic wait_term(input int budget, input string name);
    int waited = 0;
    while (!(bus.Done | bus.Foul | bus.Timeout) && waited < budget) begin
      @(negedge Clock);
      waited++;
    end
    check(name, 32'(bus.Done | bus.Foul | bus.Timeout), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rt"},      32'(bus.RT_MS),   32'd0);
    check({tag, "_et"},      32'(bus.ET_MS),   32'd0);
    check({tag, "_busy"},    32'(bus.Busy),    32'd0);
    check({tag, "_done"},    32'(bus.Done),    32'd0);
    check({tag, "_foul"},    32'(bus.Foul),    32'd0);
    check({tag, "_timeout"}, 32'(bus.Timeout), 32'd0);
  endtask

  // RT = floor((M+2)/4) for SB dropped M clocks after GRN; ET = floor(K/4) for FB K clocks after SB drop.
  initial begin
    Reset   = 1'b0;
    bus.SB  = 1'b0;
    bus.FB  = 1'b0;
    bus.GRN = 1'b0;
    bus.RED = 1'b0;

    do_reset();
    check_idle("reset");

    // Normal run: M=40 -> RT 10, K=80 -> ET 20.
    push_exp(10, 20, 1'b1, 1'b0, 1'b0);
    stage();
    bus.GRN = 1'b1;
    cycles(40);
    check("react_busy", 32'(bus.Busy), 32'd1);
    bus.SB = 1'b0;
    cycles(80);
    bus.FB = 1'b1;
    wait_term(200, "normal_finished");
    cycles(5);
    check("done_hold_rt", 32'(bus.RT_MS), 32'd10);
    check("done_hold_et", 32'(bus.ET_MS), 32'd20);

    // Red before green.
    do_reset();
    push_exp(0, 0, 1'b0, 1'b1, 1'b0);
    stage();
    bus.RED = 1'b1;
    cycles(1);
    check("foul_latency", 32'(bus.Foul), 32'd1);
    wait_term(10, "foul_finished");
    bus.GRN = 1'b1;
    cycles(3);
    check("foul_no_done", 32'(bus.Done), 32'd0);

    // Reaction counter saturates: M=16400 -> 4100 ticks, clamps at 4095; K=20 -> ET 5.
    do_reset();
    push_exp(4095, 5, 1'b1, 1'b0, 1'b0);
    stage();
    bus.GRN = 1'b1;
    cycles(16400);
    bus.SB = 1'b0;
    cycles(20);
    bus.FB = 1'b1;
    wait_term(100, "sat_finished");

    // No finish: timeout at 50 ms.
    do_reset();
    push_exp(10, 50, 1'b0, 1'b0, 1'b1);
    stage();
    bus.GRN = 1'b1;
    cycles(40);
    bus.SB = 1'b0;
    wait_term(400, "timeout_finished");
    cycles(20);
    check("timeout_hold_et", 32'(bus.ET_MS),   32'd50);
    check("timeout_hold",    32'(bus.Timeout), 32'd1);

    // Reset pulse mid-RUN clears everything on the next cycle.
    do_reset();
    stage();
    bus.GRN = 1'b1;
    cycles(20);
    bus.SB = 1'b0;
    cycles(30);
    check("run_busy", 32'(bus.Busy), 32'd1);
    check("run_et_counting", 32'(bus.ET_MS > 16'd0), 32'd1);
    Reset = 1'b0;
    cycles(1);
    check_idle("midrun_reset");
    Reset   = 1'b1;
    bus.GRN = 1'b0;
    cycles(3);

    // FB already high entering RUN: no finish until a fresh edge. M=8 -> RT 2, K=52 -> ET 13.
    do_reset();
    push_exp(2, 13, 1'b1, 1'b0, 1'b0);
    stage();
    bus.GRN = 1'b1;
    cycles(2);
    bus.FB = 1'b1;
    cycles(6);
    bus.SB = 1'b0;
    cycles(40);
    check("fb_held_busy", 32'(bus.Busy), 32'd1);
    check("fb_held_done", 32'(bus.Done), 32'd0);
    bus.FB = 1'b0;
    cycles(12);
    bus.FB = 1'b1;
    wait_term(100, "fb_edge_finished");

    // Red during REACT after 9 clocks: ticks on clocks 4 and 8 of REACT -> RT 2.
    do_reset();
    push_exp(2, 0, 1'b0, 1'b1, 1'b0);
    stage();
    bus.GRN = 1'b1;
    cycles(9);
    bus.RED = 1'b1;
    wait_term(10, "react_foul_finished");

    // Car backs out of the beam: green is ignored once back in IDLE.
    do_reset();
    stage();
    bus.SB = 1'b0;
    cycles(4);
    bus.GRN = 1'b1;
    cycles(8);
    check("backout_busy", 32'(bus.Busy), 32'd0);
    check("backout_rt",   32'(bus.RT_MS), 32'd0);

    cycles(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
